// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: assembled byte, status flags and acknowledge.
// The receiver drives through the master modport; the downstream command layer uses slave.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;
  logic       clr_rdy;

  modport master (output rx_data, rdy, frm_err, ovr, input clr_rdy);
  modport slave  (input rx_data, rdy, frm_err, ovr, output clr_rdy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first, idle-high line, BAUD_CLKS clocks per bit.
// Double-synchronises RX, centre-samples every bit and reports the byte via rdy/clr_rdy.
module uart_rx #(
  parameter int BAUD_CLKS = 43,
  parameter int HALF_CLKS = BAUD_CLKS / 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     RX,
  uart_rx_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [5:0] HALF_CNT  = 6'(HALF_CLKS);
  localparam logic [5:0] BAUD_LAST = 6'(BAUD_CLKS - 1);

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [5:0] baud_cnt_q, baud_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rdy_q, rdy_d;
  logic       frm_err_q, frm_err_d;
  logic       ovr_q, ovr_d;
  logic       fall;
  logic [5:0] baud_inc;

  always_comb begin
    sync1_d    = RX;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    fall       = ~sync2_q & prev_q;
    baud_inc   = baud_cnt_q + 6'd1;
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    frm_err_d  = frm_err_q;
    ovr_d      = ovr_q;

    if (bus.clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          baud_cnt_d = 6'd0;
        end
      end
      // The start sample fires on the edge where the count reaches HALF_CLKS,
      // which puts it HALF_CLKS edges after entering START (centre of the start bit).
      START: begin
        baud_cnt_d = baud_inc;
        if (baud_inc == HALF_CNT) begin
          baud_cnt_d = 6'd0;
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
      end
      DATA: begin
        baud_cnt_d = baud_inc;
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = 6'd0;
          shift_d    = {sync2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        baud_cnt_d = baud_inc;
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = 6'd0;
          state_d    = IDLE;
          // A good stop overrides a coincident clr_rdy so the new byte is never lost.
          if (sync2_q) begin
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
            frm_err_d = 1'b0;
            ovr_d     = ovr_q | rdy_q;
          end else begin
            frm_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      baud_cnt_q <= 6'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;
  assign bus.ovr     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a transmitter model drives RX, a scoreboard queue holds the
// bytes each good frame should deliver, and a monitor pops them when rdy/ovr report a byte.
module tb_uart_rx;
  localparam int BAUD = 43;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;
  logic clr_man = 1'b0;
  logic clr_auto = 1'b0;
  logic auto_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rdy_cyc = 0;
  int n_events = 0;
  int ev_base = 0;
  logic rdy_prev = 1'b0;
  logic ovr_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx_if u_if ();
  assign u_if.clr_rdy = clr_man | clr_auto;

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .RX  (rx_line),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte-report monitor: a new byte shows up as rdy rising, or as ovr rising when rdy was still set.
  always @(negedge clk) begin
    if (rst) begin
      rdy_prev = 1'b0;
      ovr_prev = 1'b0;
      clr_auto = 1'b0;
    end else begin
      clr_auto = 1'b0;
      if ((u_if.rdy && !rdy_prev) || (u_if.ovr && !ovr_prev)) begin
        n_events++;
        rdy_cyc = cyc;
        clr_auto = auto_ack;
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("sb_rx_data", 32'(u_if.rx_data), 32'(exp_b));
        end
      end
      rdy_prev = u_if.rdy;
      ovr_prev = u_if.ovr;
    end
  end

  // Called at a negedge; returns at a negedge so frames can be chained with no idle gap.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap);
    if (stop_bit) exp_q.push_back(d);
    rx_line = 1'b0;
    fall_cyc = cyc;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      repeat (BAUD) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (BAUD) @(negedge clk);
    rx_line = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_man = 1'b1;
    @(negedge clk);
    clr_man = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(u_if.rx_data), 32'h00);
    check("rst_rdy", 32'(u_if.rdy), 32'd0);
    check("rst_frm_err", 32'(u_if.frm_err), 32'd0);
    check("rst_ovr", 32'(u_if.ovr), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, latency from the RX fall to rdy
    send_frame(8'hA5, 1'b1, 30);
    check("a5_latency", 32'(rdy_cyc - fall_cyc - 1), 32'd410);
    check("a5_rdy", 32'(u_if.rdy), 32'd1);
    check("a5_frm_err", 32'(u_if.frm_err), 32'd0);
    check("a5_rx_data", 32'(u_if.rx_data), 32'hA5);
    pulse_clr();
    check("a5_clr_rdy", 32'(u_if.rdy), 32'd0);

    // Back-to-back frames, acknowledged as each byte lands
    auto_ack = 1'b1;
    ev_base = n_events;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h80, 1'b1, 30);
    check("b2b_events", 32'(n_events - ev_base), 32'd4);
    check("b2b_ovr", 32'(u_if.ovr), 32'd0);
    check("b2b_rdy", 32'(u_if.rdy), 32'd0);

    // Short low glitch is a false start
    ev_base = n_events;
    rx_line = 1'b0;
    repeat (10) @(negedge clk);
    rx_line = 1'b1;
    repeat (60) @(negedge clk);
    check("fs_events", 32'(n_events - ev_base), 32'd0);
    check("fs_state_idle", 32'(dut.state_q), 32'd0);
    send_frame(8'h3C, 1'b1, 30);
    check("fs_next_events", 32'(n_events - ev_base), 32'd1);

    // Framing error keeps the old byte, next good frame clears the flag
    ev_base = n_events;
    send_frame(8'h55, 1'b0, 20);
    check("fe_frm_err", 32'(u_if.frm_err), 32'd1);
    check("fe_rdy", 32'(u_if.rdy), 32'd0);
    check("fe_rx_data_kept", 32'(u_if.rx_data), 32'h3C);
    check("fe_events", 32'(n_events - ev_base), 32'd0);
    auto_ack = 1'b0;
    send_frame(8'h12, 1'b1, 20);
    check("fe_clear_frm_err", 32'(u_if.frm_err), 32'd0);
    check("fe_clear_rdy", 32'(u_if.rdy), 32'd1);
    pulse_clr();
    check("fe_clr_rdy", 32'(u_if.rdy), 32'd0);

    // Overrun: two bytes without acknowledge
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 20);
    check("ovr_rx_data", 32'(u_if.rx_data), 32'h22);
    check("ovr_rdy", 32'(u_if.rdy), 32'd1);
    check("ovr_ovr", 32'(u_if.ovr), 32'd1);
    pulse_clr();
    check("ovr_clr_rdy", 32'(u_if.rdy), 32'd0);
    check("ovr_clr_ovr", 32'(u_if.ovr), 32'd0);

    // Reset in the middle of bit 4; the tail of 8'hF0 is all ones so it cannot restart a frame
    send_frame(8'h77, 1'b1, 20);
    ev_base = n_events;
    rx_line = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_line = 1'b0;
      repeat (BAUD) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_rx_data", 32'(u_if.rx_data), 32'h00);
    check("mrst_rdy", 32'(u_if.rdy), 32'd0);
    check("mrst_frm_err", 32'(u_if.frm_err), 32'd0);
    check("mrst_ovr", 32'(u_if.ovr), 32'd0);
    repeat (BAUD * 5) @(negedge clk);
    check("mrst_no_rdy", 32'(u_if.rdy), 32'd0);
    check("mrst_events", 32'(n_events - ev_base), 32'd0);

    // Recovery after reset
    send_frame(8'h5A, 1'b1, 20);
    check("post_rst_rdy", 32'(u_if.rdy), 32'd1);
    check("post_rst_rx_data", 32'(u_if.rx_data), 32'h5A);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
